// File: rtl/mean_square_accum.sv
// Mean-square front end: squares signed samples with a serial shift-add multiplier
// and averages windows of 2^LOG2_N squares. Optional macro MSA_ROUND_EN selects round-to-nearest.
module mean_square_accum #(
    parameter int IN_WIDTH = 8,
    parameter int LOG2_N   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*IN_WIDTH-1:0] out_ms,
    output logic [LOG2_N-1:0]     win_cnt
);
    localparam int PW = 2 * IN_WIDTH;
    localparam int SW = PW + LOG2_N;
    localparam int CW = $clog2(IN_WIDTH) + 1;

    localparam logic [IN_WIDTH-1:0] ONE_IN   = 1;
    localparam logic [LOG2_N-1:0]   ONE_WIN  = 1;
    localparam logic [LOG2_N-1:0]   LAST_WIN = '1;
    localparam logic [CW-1:0]       ONE_BIT  = 1;
    localparam logic [CW-1:0]       LAST_BIT = CW'(IN_WIDTH - 1);
`ifdef MSA_ROUND_EN
    localparam logic [SW-1:0]       RND = SW'(1) << (LOG2_N - 1);
`else
    localparam logic [SW-1:0]       RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [IN_WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [LOG2_N-1:0]     win_q, win_d;
    logic [PW-1:0]         ms_q, ms_d;
    logic                  in_ready_q, out_valid_q;

    logic [IN_WIDTH-1:0]   mag;
    logic [SW-1:0]         total;
    logic [SW-1:0]         scaled;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        bit_d    = bit_q;
        sum_d    = sum_q;
        win_d    = win_q;
        ms_d     = ms_q;

        // Unsigned magnitude: the most negative sample maps to 2^(IN_WIDTH-1) exactly.
        mag    = in_data[IN_WIDTH-1] ? (~in_data + ONE_IN) : in_data;
        total  = sum_q + {{LOG2_N{1'b0}}, prod_q};
        scaled = (total + RND) >> LOG2_N;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d  = {{IN_WIDTH{1'b0}}, mag};
                    mplier_d = mag;
                    prod_d   = '0;
                    bit_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                bit_d    = bit_q + ONE_BIT;
                if (bit_q == LAST_BIT) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (win_q == LAST_WIN) begin
                    ms_d    = scaled[PW-1:0];
                    sum_d   = '0;
                    win_d   = '0;
                    state_d = OUT;
                end else begin
                    sum_d   = total;
                    win_d   = win_q + ONE_WIN;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they stay low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            bit_q       <= '0;
            sum_q       <= '0;
            win_q       <= '0;
            ms_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            bit_q       <= bit_d;
            sum_q       <= sum_d;
            win_q       <= win_d;
            ms_q        <= ms_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == OUT);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ms    = ms_q;
    assign win_cnt   = win_q;
endmodule

// File: tb/tb_mean_square_accum.sv
// Directed bench for mean_square_accum: a square-sum model pushes expected window
// results to a queue that is popped at each output handshake.
module tb_mean_square_accum;
    localparam int W  = 8;
    localparam int LN = 3;
    localparam int N  = 1 << LN;
`ifdef MSA_ROUND_EN
    localparam int RND = 1 << (LN - 1);
`else
    localparam int RND = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_ms;
    logic [LN-1:0]   win_cnt;

    mean_square_accum #(.IN_WIDTH(W), .LOG2_N(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ms    (out_ms),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int model_acc = 0;
    int model_cnt = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send(input int v);
        int got;
        int low;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("in_ready_wait", got, 1);
        in_data  = v[W-1:0];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_acc += v * v;
        model_cnt++;
        if (model_cnt == N) begin
            exp_q.push_back(16'((model_acc + RND) >> LN));
            model_acc = 0;
            model_cnt = 0;
        end else begin
            low = 0;
            while (!in_ready && low < 50) begin
                low++;
                @(negedge clk);
            end
            chk("in_ready_low_cycles", low, W + 1);
            chk("win_cnt_after_acc", int'(win_cnt), model_cnt);
        end
        $display("sample %0d accepted, window count %0d", v, model_cnt);
    endtask

    task automatic wait_out(input int hold);
        int got;
        int expv;
        out_ready = (hold == 0);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("out_valid_wait", got, 1);
        chk("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
        expv = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
        chk("out_ms", int'(out_ms), expv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_out_ms", int'(out_ms), expv);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_win_cnt", int'(win_cnt), 0);
        chk("post_out_ms_held", int'(out_ms), expv);
        $display("window result out_ms=%0d expected=%0d hold=%0d", out_ms, expv, hold);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_ms", int'(out_ms), 0);
        chk("rst_win_cnt", int'(win_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);

        // Constant window, consumer already ready.
        for (int i = 0; i < N; i++) send(3);
        wait_out(0);

        // Negative extreme.
        for (int i = 0; i < N; i++) send(-128);
        wait_out(0);

        // Rounding case 1..8, with backpressure.
        for (int i = 1; i <= N; i++) send(i);
        wait_out(5);

        // Mixed signs including both extremes.
        send(-5); send(7); send(-1); send(0);
        send(127); send(-128); send(3); send(-3);
        wait_out(2);

        // Reset in the middle of a window, during MUL.
        for (int i = 0; i < 5; i++) send(2);
        in_data  = 8'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_ms", int'(out_ms), 0);
        chk("midrst_win_cnt", int'(win_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        $display("reset applied mid-window");
        for (int i = 0; i < N; i++) send(1);
        wait_out(0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
